uart_instruction_queue: RTL and testbench
=========================================

// Module: uart_instruction_queue
// PURPOSE
//  Parametrised successor of the single-instruction UART stepper. It sits between the UART byte
//  receiver and the processor core. It assembles received bytes into instructions and buffers them
//  in a FIFO. For each instruction it drives a gated processor clock for a fixed number of cycles,
//  then requests a register-file dump. A batch mode defers the dump until the queue drains.
// PARAMETERS
//  INST_W      32            instruction width in bits; multiple of 8
//  FIFO_DEPTH  4             instruction queue depth; power of 2, >=2
//  PROC_CYCLES 5             clk_proc rising edges per instruction; 1..255
//  NOOP        32'h00000013  word driven on inst_out when no instruction is being injected
// PORTS
//  clk12         in   1                  system clock; all logic on posedge
//  rst           in   1                  synchronous reset, active-high
//  rx_byte       in   8                  received UART byte
//  rx_valid      in   1                  one-cycle strobe: rx_byte valid
//  rx_abort      in   1                  discard partially assembled instruction
//  batch         in   1                  1: dump regfile only when queue empties
//  tx_busy       in   1                  regfile transmitter busy; send_regfile must not pulse while high
//  clk_proc      out  1                  gated processor clock
//  inst_out      out  INST_W             instruction presented to the core
//  send_regfile  out  1                  one-cycle request to regfile transmitter
//  exec_busy     out  1                  high in any state other than IDLE
//  fifo_count    out  $clog2(DEPTH)+1    instructions queued
//  overflow      out  1                  sticky: an instruction was dropped because the queue was full
// BEHAVIOUR
//  Reset values: clk_proc=1; inst_out=NOOP; send_regfile=0; exec_busy=0; fifo_count=0; overflow=0;
//   byte counter=0; state=IDLE.
//  Assembler: big-endian; the first byte after an instruction boundary is bits [INST_W-1:INST_W-8].
//   - Byte counter wraps at INST_W/8. The completing byte pushes the word one cycle after its rx_valid.
//   - rx_abort clears the counter and wins over a same-cycle rx_valid.
//  FIFO: the push is accepted if not full, or if a pop occurs in the same cycle.
//   - Otherwise the word is dropped and overflow is set until rst.
//   - Simultaneous push+pop leaves fifo_count unchanged.
//  Execute FSM:
//   - IDLE: clk_proc=1. If the queue is non-empty and tx_busy=0: pop into inst_reg, cnt<=0,
//     clk_proc<=0, go to RUN.
//   - RUN: clk_proc toggles every clk12. cnt increments on each 0->1 transition of clk_proc.
//     inst_out=inst_reg while cnt==0, else NOOP; inst_reg is therefore valid at the first rising edge.
//     Once cnt reaches PROC_CYCLES with clk_proc=1, go to SEND_CHK (clk_proc held at 1).
//     RUN lasts exactly 2*PROC_CYCLES clk12 cycles.
//   - SEND_CHK: if batch=1 and the queue is non-empty, go to IDLE (no dump).
//     Otherwise go to SEND.
//   - SEND: wait while tx_busy=1. Then pulse send_regfile for 1 cycle and go to IDLE.
//  Batch may change at any time; it is sampled only in SEND_CHK.
//  Latency: byte->push 1 cycle; pop->first clk_proc rise 2 cycles; the last rise is followed by
//   send_regfile after 2 cycles if tx_busy=0.
//  Reset mid-RUN: clk_proc=1 and inst_out=NOOP on the next edge; queue and partial word are lost.
//  Bytes keep being accepted during RUN/SEND; execution never blocks reception.
// TESTING
//  1. rst, then bytes 00 00 00 93 (batch=0) -> inst_out=0x00000093 at the first clk_proc rise;
//     exactly 5 clk_proc rises; 1 send_regfile pulse; clk_proc ends at 1.
//  2. Push 3 instructions back-to-back, batch=1 -> 15 clk_proc rises total; a single send_regfile
//     after the third instruction; fifo_count goes 3->0.
//  3. With FIFO_DEPTH=4, tx_busy=1 held, send 5 instructions -> fifo_count=4, overflow=1, no
//     clk_proc activity; release tx_busy -> 4 instructions execute.
//  4. Send 2 bytes, pulse rx_abort, send 4 bytes 11 22 33 44 -> executed word is 0x11223344.
//  5. tx_busy=1 during SEND -> send_regfile stays 0 and clk_proc stays 1; tx_busy falls ->
//     exactly one pulse on the next cycle.
//  6. Assert rst on the 3rd clk12 cycle of RUN -> next cycle clk_proc=1, inst_out=NOOP,
//     fifo_count=0, overflow=0, exec_busy=0.

Source files
------------

// File: rtl/uart_instruction_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_instruction_queue_if
// Description : Byte stream from the UART receiver into the instruction
//               queue.
//               rx_byte  [7:0] : received byte
//               rx_valid       : one-cycle strobe, rx_byte is valid
//               rx_abort       : discard the partially assembled instruction
//               master : UART receiver side (drives)
//               slave  : instruction queue side (samples)
// Revision    : 1.0  initial release
// ============================================================================
interface uart_instruction_queue_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_abort;

  modport master (
    output rx_byte,
    output rx_valid,
    output rx_abort
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input rx_abort
  );
endinterface : uart_instruction_queue_if
`default_nettype wire

// File: rtl/uart_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_instruction_queue
// Description : Assembles UART bytes (big-endian) into instructions and
//               buffers them in a FIFO. Each instruction is presented to the
//               core while a gated processor clock is driven for
//               PROC_CYCLES rising edges. After that a register-file dump is
//               requested, or deferred until the queue drains when batch=1.
// Ports       : clk12_i        system clock, all logic on posedge
//               rst_i          synchronous active-high reset
//               rx_if          byte stream (rx_byte / rx_valid / rx_abort)
//               batch_i        1: dump regfile only once the queue is empty
//               tx_busy_i      regfile transmitter busy
//               clk_proc_o     gated processor clock
//               inst_out_o     instruction presented to the core
//               send_regfile_o one-cycle request to the regfile transmitter
//               exec_busy_o    high whenever the executor is not idle
//               fifo_count_o   number of queued instructions
//               overflow_o     sticky: an instruction was dropped (full)
// Revision    : 1.0  initial release
// ============================================================================
module uart_instruction_queue #(
  parameter int unsigned       INST_W      = 32,
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter int unsigned       PROC_CYCLES = 5,
  parameter logic [INST_W-1:0] NOOP        = 32'h00000013
) (
  input  wire                          clk12_i,
  input  wire                          rst_i,
  uart_instruction_queue_if.slave      rx_if,
  input  wire                          batch_i,
  input  wire                          tx_busy_i,
  output logic                         clk_proc_o,
  output logic [INST_W-1:0]            inst_out_o,
  output logic                         send_regfile_o,
  output logic                         exec_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         overflow_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int unsigned NBYTES = INST_W / 8;
  localparam int unsigned BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BCNT_W-1:0] BYTE_LAST  = BCNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]        PROC_LAST  = 8'(PROC_CYCLES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_SEND_CHK = 2'd2;
  localparam logic [1:0] S_SEND     = 2'd3;

  // --------------------------------------------------------------------------
  // Byte assembler
  // --------------------------------------------------------------------------
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [INST_W-1:0] word_q, word_d;
  logic [INST_W-1:0] shifted;
  logic              push_q, push_d;

  // New bytes enter at the bottom; after NBYTES shifts the first byte of the
  // instruction sits in the top byte lane.
  generate
    if (NBYTES > 1) begin : g_shift_multi
      assign shifted = {word_q[INST_W-9:0], rx_if.rx_byte};
    end else begin : g_shift_single
      assign shifted = rx_if.rx_byte;
    end
  endgenerate

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    push_d     = 1'b0;
    if (rx_if.rx_abort) begin
      byte_cnt_d = '0;
    end else if (rx_if.rx_valid) begin
      word_d = shifted;
      if (byte_cnt_q == BYTE_LAST) begin
        byte_cnt_d = '0;
        push_d     = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction FIFO
  // --------------------------------------------------------------------------
  logic [INST_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full;
  logic              fifo_pop;
  logic              push_ok;
  logic [INST_W-1:0] fifo_head;

  logic [1:0]        state_q, state_d;

  assign fifo_full = (count_q == COUNT_FULL);
  assign fifo_pop  = (state_q == S_IDLE) && (count_q != '0) && !tx_busy_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push_q && (!fifo_full || fifo_pop);
  assign fifo_head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_q & ~push_ok);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  // --------------------------------------------------------------------------
  // Execute FSM
  // --------------------------------------------------------------------------
  logic              clk_proc_q, clk_proc_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              run_done;

  // Last rising edge of the processor clock has been issued.
  assign run_done = clk_proc_q && (pcnt_q == PROC_LAST);

  // State register
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_pop) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_done) begin
          state_d = S_SEND_CHK;
        end
      end
      S_SEND_CHK: begin
        // In batch mode the dump waits until the last queued instruction.
        if (batch_i && (count_q != '0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Processor clock, edge counter and instruction register
  always_comb begin
    clk_proc_d = 1'b1;
    pcnt_d     = pcnt_q;
    inst_d     = inst_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_pop) begin
          inst_d     = fifo_head;
          pcnt_d     = '0;
          clk_proc_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!run_done) begin
          clk_proc_d = ~clk_proc_q;
          if (!clk_proc_q) begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      default: clk_proc_d = 1'b1;
    endcase
  end

  // Output logic. The instruction is shown only before the first rising
  // edge, so the core latches it exactly once; later edges see NOOP.
  always_comb begin
    inst_out_o     = ((state_q == S_RUN) && (pcnt_q == '0)) ? inst_q : NOOP;
    send_regfile_o = (state_q == S_SEND) && !tx_busy_i;
    exec_busy_o    = (state_q != S_IDLE);
    clk_proc_o     = clk_proc_q;
    fifo_count_o   = count_q;
    overflow_o     = overflow_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      clk_proc_q <= 1'b1;
      pcnt_q     <= '0;
      inst_q     <= NOOP;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      clk_proc_q <= clk_proc_d;
      pcnt_q     <= pcnt_d;
      inst_q     <= inst_d;
    end
  end

endmodule : uart_instruction_queue
`default_nettype wire

// File: tb/tb_uart_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_instruction_queue
// Description : Self-checking bench for uart_instruction_queue: a queue-based
//               reference model compared every cycle, directed scenarios with
//               literal expectations, then randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_instruction_queue;

  localparam int          DEPTH = 4;
  localparam int          P     = 5;
  localparam logic [31:0] NOOP  = 32'h00000013;

  logic        clk12   = 1'b0;
  logic        rst     = 1'b1;
  logic        batch   = 1'b0;
  logic        tx_busy = 1'b0;
  logic        clk_proc;
  logic [31:0] inst_out;
  logic        send_regfile;
  logic        exec_busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  uart_instruction_queue_if u_rx ();

  uart_instruction_queue #(
    .INST_W      (32),
    .FIFO_DEPTH  (DEPTH),
    .PROC_CYCLES (P),
    .NOOP        (NOOP)
  ) dut (
    .clk12_i        (clk12),
    .rst_i          (rst),
    .rx_if          (u_rx.slave),
    .batch_i        (batch),
    .tx_busy_i      (tx_busy),
    .clk_proc_o     (clk_proc),
    .inst_out_o     (inst_out),
    .send_regfile_o (send_regfile),
    .exec_busy_o    (exec_busy),
    .fifo_count_o   (fifo_count),
    .overflow_o     (overflow)
  );

  always #5 clk12 = ~clk12;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: queue of words, byte list, and elapsed time since the
  // current instruction was started (-1 = nothing executing).
  //   t in 0..2P-1 : processor clock running, clk_proc = t odd
  //   t == 2P      : deciding whether to dump
  //   t == 2P+1    : waiting for the transmitter, then dump
  // --------------------------------------------------------------------------
  logic [31:0] q[$];
  bit          m_ovf     = 0;
  int          m_nb      = 0;
  logic [31:0] m_asm     = '0;
  bit          m_pend    = 0;
  logic [31:0] m_pend_w  = '0;
  int          m_t       = -1;
  logic [31:0] m_word    = '0;
  bit          started   = 0;
  int          m_sz;
  bit          m_pop;
  logic [31:0] m_popped;

  always @(posedge clk12) begin
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_nb    = 0;
      m_pend  = 0;
      m_t     = -1;
      started = 1;
    end else begin
      m_sz  = q.size();
      m_pop = (m_t < 0) && (m_sz > 0) && !tx_busy;
      if (m_pop) m_popped = q.pop_front();
      if (m_pend) begin
        if (m_sz < DEPTH || m_pop) q.push_back(m_pend_w);
        else m_ovf = 1;
      end
      m_pend = 0;
      if (u_rx.rx_abort) begin
        m_nb = 0;
      end else if (u_rx.rx_valid) begin
        m_asm = {m_asm[23:0], u_rx.rx_byte};
        m_nb++;
        if (m_nb == 4) begin
          m_nb     = 0;
          m_pend   = 1;
          m_pend_w = m_asm;
        end
      end
      if (m_t < 0) begin
        if (m_pop) begin
          m_t    = 0;
          m_word = m_popped;
        end
      end else if (m_t < 2*P) begin
        m_t++;
      end else if (m_t == 2*P) begin
        m_t = (batch && m_sz > 0) ? -1 : 2*P + 1;
      end else if (!tx_busy) begin
        m_t = -1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison and event counters (sampled on the falling edge)
  // --------------------------------------------------------------------------
  logic        e_clk;
  logic [31:0] e_inst;
  logic        e_send;
  logic        e_busy;

  int          rises     = 0;
  int          sends     = 0;
  int          max_cnt   = 0;
  bit          got_first = 0;
  logic [31:0] first_inst = '0;
  logic        prev_clk  = 1'b1;
  logic [31:0] prev_inst = '0;

  always @(negedge clk12) begin
    if (started) begin
      e_clk  = (m_t >= 0 && m_t < 2*P) ? ((m_t % 2) == 1) : 1'b1;
      e_inst = (m_t == 0) ? m_word : NOOP;
      e_send = (m_t == 2*P + 1) && !tx_busy;
      e_busy = (m_t >= 0);
      check("clk_proc",     32'(clk_proc),     32'(e_clk));
      check("inst_out",     inst_out,          e_inst);
      check("send_regfile", 32'(send_regfile), 32'(e_send));
      check("exec_busy",    32'(exec_busy),    32'(e_busy));
      check("fifo_count",   32'(fifo_count),   32'(q.size()));
      check("overflow",     32'(overflow),     32'(m_ovf));
    end
    if (prev_clk === 1'b0 && clk_proc === 1'b1) begin
      rises++;
      if (!got_first) begin
        got_first  = 1;
        first_inst = prev_inst;
      end
    end
    if (send_regfile === 1'b1) sends++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    prev_clk  = clk_proc;
    prev_inst = inst_out;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk12);
    #1;
  endtask

  task automatic clear_counts();
    rises     = 0;
    sends     = 0;
    max_cnt   = 0;
    got_first = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_rx.rx_valid = 1'b1;
    u_rx.rx_byte  = b;
    tick();
    u_rx.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_t < 0 && q.size() == 0 && !m_pend) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) timeout_fail(name);
    tick();
  endtask

  task automatic wait_t(input string name, input int target, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_t == target) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) timeout_fail(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    u_rx.rx_byte  = 8'h00;
    u_rx.rx_valid = 1'b0;
    u_rx.rx_abort = 1'b0;
    do_reset();

    // Reset state
    check("rst_clk_proc", 32'(clk_proc),     32'd1);
    check("rst_inst_out", inst_out,          32'h00000013);
    check("rst_send",     32'(send_regfile), 32'd0);
    check("rst_busy",     32'(exec_busy),    32'd0);
    check("rst_count",    32'(fifo_count),   32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);

    // 1: single instruction, immediate dump
    clear_counts();
    send_word(32'h00000093);
    wait_idle("t1_idle", 200);
    check("t1_rises",      32'(rises),    32'd5);
    check("t1_sends",      32'(sends),    32'd1);
    check("t1_first_inst", first_inst,    32'h00000093);
    check("t1_clk_end",    32'(clk_proc), 32'd1);

    // 2: three queued instructions in batch mode, one dump at the end
    batch   = 1'b1;
    tx_busy = 1'b1;
    clear_counts();
    send_word(32'h00100093);
    send_word(32'h00200113);
    send_word(32'h00300193);
    tick();
    check("t2_count3", 32'(fifo_count), 32'd3);
    tx_busy = 1'b0;
    wait_idle("t2_idle", 400);
    check("t2_rises",  32'(rises),      32'd15);
    check("t2_sends",  32'(sends),      32'd1);
    check("t2_max",    32'(max_cnt),    32'd3);
    check("t2_count0", 32'(fifo_count), 32'd0);
    batch = 1'b0;

    // 3: overflow while the transmitter blocks execution
    tx_busy = 1'b1;
    clear_counts();
    for (int i = 0; i < 5; i++) send_word(32'hA0000000 | 32'(i));
    tick();
    tick();
    check("t3_count",    32'(fifo_count), 32'd4);
    check("t3_overflow", 32'(overflow),   32'd1);
    check("t3_rises0",   32'(rises),      32'd0);
    check("t3_busy",     32'(exec_busy),  32'd0);
    tx_busy = 1'b0;
    wait_idle("t3_idle", 600);
    check("t3_rises",    32'(rises),      32'd20);
    check("t3_sends",    32'(sends),      32'd4);
    check("t3_ovf_held", 32'(overflow),   32'd1);
    do_reset();

    // 4: abort discards partial word, and wins over a same-cycle byte
    clear_counts();
    send_byte(8'hAA);
    send_byte(8'hBB);
    u_rx.rx_abort = 1'b1;
    tick();
    u_rx.rx_abort = 1'b0;
    send_byte(8'hCC);
    u_rx.rx_abort = 1'b1;
    send_byte(8'hEE);
    u_rx.rx_abort = 1'b0;
    send_word(32'h11223344);
    wait_idle("t4_idle", 200);
    check("t4_first_inst", first_inst,  32'h11223344);
    check("t4_rises",      32'(rises),  32'd5);

    // 5: dump held off by a busy transmitter
    clear_counts();
    send_word(32'h00500293);
    wait_t("t5_run", 1, 50);
    tx_busy = 1'b1;
    wait_t("t5_send", 2*P + 1, 50);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_send", 32'(sends),     32'd0);
    check("t5_clk_hi",  32'(clk_proc),  32'd1);
    check("t5_busy",    32'(exec_busy), 32'd1);
    tx_busy = 1'b0;
    tick();
    check("t5_one_send", 32'(sends),     32'd1);
    check("t5_idle",     32'(exec_busy), 32'd0);
    wait_idle("t5_idle", 100);

    // 6: reset in the third cycle of RUN
    tx_busy = 1'b1;
    send_word(32'h00600313);
    send_word(32'h00700393);
    tick();
    tx_busy = 1'b0;
    wait_t("t6_run", 2, 50);
    check("t6_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_clk",   32'(clk_proc),   32'd1);
    check("t6_inst",  inst_out,        32'h00000013);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_ovf",   32'(overflow),   32'd0);
    check("t6_busy",  32'(exec_busy),  32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      u_rx.rx_valid = 1'($urandom_range(0, 1));
      u_rx.rx_byte  = 8'($urandom);
      u_rx.rx_abort = ($urandom_range(0, 49) == 0);
      tx_busy       = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 15) == 0) batch = 1'($urandom_range(0, 1));
      rst           = ($urandom_range(0, 499) == 0);
      tick();
    end
    u_rx.rx_valid = 1'b0;
    u_rx.rx_abort = 1'b0;
    rst           = 1'b0;
    tx_busy       = 1'b0;
    wait_idle("rand_drain", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_instruction_queue
`default_nettype wire
